// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The product or quotient/remainder is computed combinationally from the
// operands when an op is accepted. It is held in temporary registers while
// Busy counts down the op latency, then written into HI/LO in one step.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_Result
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   counter_reg, counter_next;
  logic               busy_reg, busy_next;
  logic [31:0]        hi_reg, hi_next;
  logic [31:0]        lo_reg, lo_next;
  logic [31:0]        tmp_hi_reg, tmp_hi_next;
  logic [31:0]        tmp_lo_reg, tmp_lo_next;
  logic               commit_reg, commit_next;

  // Arithmetic datapath signals
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor_safe;
  logic [31:0]        abs_a, abs_b;
  logic [31:0]        uq, ur, sq_mag, sr_mag, sq, sr;
  logic [31:0]        result_hi, result_lo;
  logic               result_valid;
  logic               is_arith_op;
  logic [CNT_W-1:0]   op_cycles;

  // Full 64-bit products; operands are explicitly widened so no bits are lost
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'h0, A} * {32'h0, B};

  // A zero divisor is replaced by 1 so the dividers never see x; the result is discarded anyway
  assign divisor_safe = (B == 32'h0) ? 32'h1 : B;
  assign uq           = A / divisor_safe;
  assign ur           = A % divisor_safe;

  // Signed divide on magnitudes: 0x80000000 / -1 naturally yields 0x80000000 rem 0
  assign abs_a  = A[31] ? (32'h0 - A) : A;
  assign abs_b  = B[31] ? (32'h0 - B) : divisor_safe;
  assign sq_mag = abs_a / abs_b;
  assign sr_mag = abs_a % abs_b;
  assign sq     = (A[31] ^ B[31]) ? (32'h0 - sq_mag) : sq_mag;
  assign sr     = A[31] ? (32'h0 - sr_mag) : sr_mag;

  // Select the pending result and latency for the presented op
  always_comb begin
    result_hi    = 32'h0;
    result_lo    = 32'h0;
    result_valid = 1'b1;
    op_cycles    = CNT_W'(MULT_CYCLES);
    unique case (MDUOp)
      OP_MULT:  {result_hi, result_lo} = prod_s;
      OP_MULTU: {result_hi, result_lo} = prod_u;
      OP_DIV: begin
        op_cycles    = CNT_W'(DIV_CYCLES);
        result_valid = (B != 32'h0);
        result_hi    = sr;
        result_lo    = sq;
      end
      OP_DIVU: begin
        op_cycles    = CNT_W'(DIV_CYCLES);
        result_valid = (B != 32'h0);
        result_hi    = ur;
        result_lo    = uq;
      end
      default: ;
    endcase
  end

  assign is_arith_op = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
  assign Start       = is_arith_op && !busy_reg;
  assign Busy        = busy_reg;
  assign HI          = hi_reg;
  assign LO          = lo_reg;
  assign MDU_Result  = (MDUOp == OP_MFHI) ? hi_reg :
                       (MDUOp == OP_MFLO) ? lo_reg : 32'h0;

  // Next-state logic: accept ops / MT writes in IDLE, count down and commit in RUN
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    busy_next    = busy_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    tmp_hi_next  = tmp_hi_reg;
    tmp_lo_next  = tmp_lo_reg;
    commit_next  = commit_reg;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          tmp_hi_next  = result_hi;
          tmp_lo_next  = result_lo;
          commit_next  = result_valid;
          counter_next = op_cycles;
          busy_next    = 1'b1;
          state_next   = RUN;
        end else if (MDUOp == OP_MTHI) begin
          hi_next = A;
        end else if (MDUOp == OP_MTLO) begin
          lo_next = A;
        end
      end
      RUN: begin
        counter_next = counter_reg - CNT_W'(1);
        if (counter_reg == CNT_W'(1)) begin
          if (commit_reg) begin
            hi_next = tmp_hi_reg;
            lo_next = tmp_lo_reg;
          end
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
    endcase
  end

  // State register; reset aborts any op in flight without committing it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      busy_reg    <= 1'b0;
      hi_reg      <= 32'h0;
      lo_reg      <= 32'h0;
      tmp_hi_reg  <= 32'h0;
      tmp_lo_reg  <= 32'h0;
      commit_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      busy_reg    <= busy_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      tmp_hi_reg  <= tmp_hi_next;
      tmp_lo_reg  <= tmp_lo_next;
      commit_reg  <= commit_next;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Testbench for mdu: an op-level reference model plus directed vectors with
// hand-computed results. Every negedge the DUT outputs are compared with the model.
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        start, busy;
  logic [31:0] hi, lo, res;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .MDUOp(op), .A(a), .B(b),
    .Start(start), .Busy(busy), .HI(hi), .LO(lo), .MDU_Result(res)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_left;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pc;

  function automatic void model_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh, output logic [31:0] rl, output bit valid);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    valid = 1'b1;
    rh = 32'h0;
    rl = 32'h0;
    case (o)
      4'd1: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {rh, rl} = sp;
      end
      4'd2: begin
        up = {32'h0, x} * {32'h0, y};
        {rh, rl} = up;
      end
      4'd3: begin
        if (y == 32'h0) valid = 1'b0;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          rl = 32'h80000000;
          rh = 32'h0;
        end else begin
          sx = x;
          sy = y;
          rl = sx / sy;
          rh = sx % sy;
        end
      end
      4'd4: begin
        if (y == 32'h0) valid = 1'b0;
        else begin
          rl = x / y;
          rh = x % y;
        end
      end
      default: valid = 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [31:0] rh, rl;
    bit v;
    if (reset) begin
      m_left = 0;
      m_hi = 32'h0;
      m_lo = 32'h0;
      m_pc = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_pc) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (op >= 4'd1 && op <= 4'd4) begin
      model_op(op, a, b, rh, rl, v);
      m_phi = rh;
      m_plo = rl;
      m_pc  = v;
      m_left = (op <= 4'd2) ? MULT_N : DIV_N;
    end else if (op == 4'd7) begin
      m_hi = a;
    end else if (op == 4'd8) begin
      m_lo = a;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp, input bit verbose);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
    end else if (verbose) begin
      $display("ok   %s value=%08h t=%0t", name, act, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      logic        e_busy, e_start;
      logic [31:0] e_res;
      e_busy  = (m_left > 0);
      e_start = (op >= 4'd1 && op <= 4'd4) && !e_busy;
      e_res   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'h0;
      cmp("model_busy",  {31'h0, busy},  {31'h0, e_busy},  1'b0);
      cmp("model_start", {31'h0, start}, {31'h0, e_start}, 1'b0);
      cmp("model_hi",    hi,  m_hi,  1'b0);
      cmp("model_lo",    lo,  m_lo,  1'b0);
      cmp("model_res",   res, e_res, 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    #1;
    op = o;
    a  = x;
    b  = y;
  endtask

  // Idles until Busy drops (bounded), returning how many cycles Busy was seen high
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(4'd0, 32'h5555AAAA, 32'h00001234);
      #1;
      if (busy) n++;
      else break;
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    cyc(o, x, y);
    #1;
    cmp({name, "_start"}, {31'h0, start}, 32'h1, 1'b1);
    wait_idle(n);
    cmp({name, "_busy_cycles"}, n, exp_n, 1'b1);
    cmp({name, "_hi"}, hi, exp_hi, 1'b1);
    cmp({name, "_lo"}, lo, exp_lo, 1'b1);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    cmp_en = 1'b1;
    #1;
    cmp("reset_busy", {31'h0, busy}, 32'h0, 1'b1);
    cmp("reset_hi", hi, 32'h0, 1'b1);
    cmp("reset_lo", lo, 32'h0, 1'b1);

    run_op("mult",   4'd1, 32'hFFFFFFFD, 32'd5, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu",  4'd2, 32'hFFFFFFFF, 32'd2, MULT_N, 32'h00000001, 32'hFFFFFFFE);
    run_op("div",    4'd3, 32'hFFFFFFF9, 32'd2, DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",   4'd4, 32'd7, 32'd2, DIV_N, 32'd1, 32'd3);
    run_op("div0",   4'd3, 32'd99, 32'd0, DIV_N, 32'd1, 32'd3);
    run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, DIV_N, 32'h0, 32'h80000000);
    run_op("mults",  4'd1, 32'hFFFF0000, 32'h00010000, MULT_N, 32'hFFFFFFFF, 32'h00000000);

    // DIVU with MULT/MTHI presented while busy, then MULT right after Busy falls
    cyc(4'd4, 32'd100, 32'd7);
    for (int i = 0; i < DIV_N; i++) begin
      if (i < 5) cyc(4'd1, 32'd3, 32'd3);
      else cyc(4'd7, 32'hDEADBEEF, 32'd1);
      #1;
      if (i == 0) cmp("busy_start_blocked", {31'h0, start}, 32'h0, 1'b1);
    end
    cyc(4'd1, 32'd6, 32'd7);
    #1;
    cmp("b2b_divu_hi", hi, 32'd2, 1'b1);
    cmp("b2b_divu_lo", lo, 32'd14, 1'b1);
    cmp("b2b_start", {31'h0, start}, 32'h1, 1'b1);
    wait_idle(n);
    cmp("b2b_mult_busy_cycles", n, MULT_N, 1'b1);
    cmp("b2b_mult_lo", lo, 32'd42, 1'b1);

    // MT / MF
    cyc(4'd7, 32'h12345678, 32'h0);
    cyc(4'd5, 32'h0, 32'h0);
    #1;
    cmp("mfhi", res, 32'h12345678, 1'b1);
    cyc(4'd8, 32'h000000AB, 32'h0);
    cyc(4'd6, 32'h0, 32'h0);
    #1;
    cmp("mflo", res, 32'h000000AB, 1'b1);

    // Reset in the middle of a MULT
    cyc(4'd1, 32'd2, 32'd3);
    cyc(4'd0, 32'h0, 32'h0);
    cyc(4'd0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    cmp("midreset_busy", {31'h0, busy}, 32'h0, 1'b1);
    cmp("midreset_hi", hi, 32'h0, 1'b1);
    cmp("midreset_lo", lo, 32'h0, 1'b1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (8) cyc(4'd0, 32'h0, 32'h0);
    #1;
    cmp("midreset_no_commit_hi", hi, 32'h0, 1'b1);
    cmp("midreset_no_commit_lo", lo, 32'h0, 1'b1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
